// File: rtl/cn_clk_gen.sv
// Programmable divided-clock generator: ideal divided clock plus a skewed copy.
// Divide ratio and skew change only at period boundaries, so stopping or reconfiguring never leaves a runt pulse.
module cn_clk_gen #(
  parameter int CNT_W       = 8,
  parameter int SKEW_W      = 4,
  parameter int DEFAULT_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [SKEW_W-1:0] cfg_skew,
  output logic              clk_ideal,
  output logic              clk_out,
  output logic              period_start,
  output logic              locked
);

  // History bits beyond the live clk_ideal register; enough for skew up to 2**SKEW_W-1.
  localparam int SR_D = (2 ** SKEW_W) - 2;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    if (d < CNT_W'(2)) return CNT_W'(2);
    else               return d;
  endfunction

  function automatic logic [SKEW_W-1:0] clamp_skew(input logic [SKEW_W-1:0] s,
                                                   input logic [CNT_W-1:0]  d);
    logic [CNT_W-1:0] lim;
    lim = d - CNT_W'(1);
    if (CNT_W'(s) > lim) return lim[SKEW_W-1:0];
    else                 return s;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  pdiv_q, pdiv_d;
  logic [SKEW_W-1:0] pskew_q, pskew_d;
  logic [SR_D-1:0]   sr_q, sr_d;
  logic [1:0]        per_q, per_d;
  logic              clk_ideal_q, clk_ideal_d;
  logic              clk_out_q, clk_out_d;
  logic              pstart_q, pstart_d;
  logic              locked_q, locked_d;
  logic              ready_q, ready_d;

  logic              accept_s, wrap_s, apply_s, on_s;
  logic [CNT_W-1:0]  cdiv_s;
  logic [SKEW_W-1:0] cskew_s;
  logic [CNT_W:0]    half_s;
  logic [SR_D:0]     hist_s;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    skew_d   = skew_q;
    pend_d   = pend_q;
    pdiv_d   = pdiv_q;
    pskew_d  = pskew_q;
    apply_s  = 1'b0;
    accept_s = cfg_valid && ready_q;
    wrap_s   = (state_q != ST_STOPPED) && (cnt_q == div_q - CNT_W'(1));
    cdiv_s   = clamp_div(cfg_div);
    cskew_s  = clamp_skew(cfg_skew, cdiv_s);

    // Stopped: config lands at once; running: it waits for the period wrap.
    if (state_q == ST_STOPPED) begin
      if (pend_q) begin
        div_d   = pdiv_q;
        skew_d  = pskew_q;
        pend_d  = 1'b0;
        apply_s = 1'b1;
      end else if (accept_s) begin
        div_d   = cdiv_s;
        skew_d  = cskew_s;
        apply_s = 1'b1;
      end else begin
        apply_s = 1'b0;
      end
    end else begin
      if (wrap_s && pend_q) begin
        div_d   = pdiv_q;
        skew_d  = pskew_q;
        pend_d  = 1'b0;
        apply_s = 1'b1;
      end else if (accept_s) begin
        pend_d  = 1'b1;
        pdiv_d  = cdiv_s;
        pskew_d = cskew_s;
      end else begin
        apply_s = 1'b0;
      end
    end

    case (state_q)
      ST_STOPPED: begin
        cnt_d   = '0;
        state_d = enable ? ST_RUNNING : ST_STOPPED;
      end
      ST_RUNNING, ST_STOPPING: begin
        cnt_d = wrap_s ? '0 : cnt_q + CNT_W'(1);
        if (enable)      state_d = ST_RUNNING;
        else if (wrap_s) state_d = ST_STOPPED;
        else             state_d = ST_STOPPING;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STOPPED;
      end
    endcase

    on_s        = (state_d != ST_STOPPED);
    half_s      = ({1'b0, div_d} + (CNT_W + 1)'(1)) >> 1;
    clk_ideal_d = on_s && ({1'b0, cnt_d} < half_s);
    pstart_d    = on_s && (cnt_d == '0);

    // hist_s[k] is clk_ideal delayed by k cycles as seen from the next cycle minus one.
    hist_s    = {sr_q, clk_ideal_q};
    sr_d      = hist_s[SR_D-1:0];
    clk_out_d = (skew_d == '0) ? clk_ideal_d : hist_s[skew_d - SKEW_W'(1)];

    if (state_d != ST_RUNNING) per_d = 2'd0;
    else if (pstart_d)         per_d = apply_s ? 2'd1 : ((per_q == 2'd3) ? 2'd3 : per_q + 2'd1);
    else                       per_d = per_q;
    locked_d = (state_d == ST_RUNNING) && (per_d == 2'd3);
    ready_d  = !pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_STOPPED;
      cnt_q       <= '0;
      div_q       <= CNT_W'(DEFAULT_DIV);
      skew_q      <= '0;
      pend_q      <= 1'b0;
      pdiv_q      <= CNT_W'(DEFAULT_DIV);
      pskew_q     <= '0;
      sr_q        <= '0;
      per_q       <= 2'd0;
      clk_ideal_q <= 1'b0;
      clk_out_q   <= 1'b0;
      pstart_q    <= 1'b0;
      locked_q    <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      skew_q      <= skew_d;
      pend_q      <= pend_d;
      pdiv_q      <= pdiv_d;
      pskew_q     <= pskew_d;
      sr_q        <= sr_d;
      per_q       <= per_d;
      clk_ideal_q <= clk_ideal_d;
      clk_out_q   <= clk_out_d;
      pstart_q    <= pstart_d;
      locked_q    <= locked_d;
      ready_q     <= ready_d;
    end
  end

  assign cfg_ready    = ready_q;
  assign clk_ideal    = clk_ideal_q;
  assign clk_out      = clk_out_q;
  assign period_start = pstart_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_cn_clk_gen.sv
// Random-stimulus bench for cn_clk_gen against a period/position reference model.
module tb_cn_clk_gen;
  localparam int CNT_W       = 8;
  localparam int SKEW_W      = 4;
  localparam int DEFAULT_DIV = 2;

  logic              clk = 1'b0;
  logic              rst, enable, cfg_valid, cfg_ready;
  logic [CNT_W-1:0]  cfg_div;
  logic [SKEW_W-1:0] cfg_skew;
  logic              clk_ideal, clk_out, period_start, locked;

  cn_clk_gen #(.CNT_W(CNT_W), .SKEW_W(SKEW_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_skew(cfg_skew), .clk_ideal(clk_ideal), .clk_out(clk_out),
    .period_start(period_start), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: generator on/off, position within the period, active config.
  bit m_on;
  int m_pos, m_div, m_skew, m_periods;
  int pend_div[$];
  int pend_skew[$];
  bit hist[$];
  bit e_ci, e_co, e_ps, e_lk, e_rdy;

  task automatic model_edge();
    bit had_pend, accept, wrap, applied, was_on, running;
    int cd, cs;
    if (rst) begin
      m_on = 0; m_pos = 0; m_div = DEFAULT_DIV; m_skew = 0; m_periods = 0;
      pend_div.delete(); pend_skew.delete(); hist.delete();
      for (int i = 0; i < 16; i++) hist.push_back(1'b0);
      e_ci = 0; e_co = 0; e_ps = 0; e_lk = 0; e_rdy = 1;
      return;
    end
    cd = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
    cs = (int'(cfg_skew) > cd - 1) ? cd - 1 : int'(cfg_skew);
    had_pend = pend_div.size() > 0;
    accept   = cfg_valid && !had_pend;
    wrap     = m_on && (m_pos == m_div - 1);
    applied  = 0;
    was_on   = m_on;
    if (!m_on && had_pend) begin
      m_div = pend_div.pop_front(); m_skew = pend_skew.pop_front(); applied = 1;
    end else if (!m_on && accept) begin
      m_div = cd; m_skew = cs; applied = 1;
    end else if (m_on && wrap && had_pend) begin
      m_div = pend_div.pop_front(); m_skew = pend_skew.pop_front(); applied = 1;
    end else if (m_on && accept) begin
      pend_div.push_back(cd); pend_skew.push_back(cs);
    end
    if (!was_on) begin
      m_pos = 0; m_on = enable;
    end else begin
      m_pos = wrap ? 0 : m_pos + 1;
      if (!enable && wrap) m_on = 0;
    end
    running = m_on && enable;
    if (!running) m_periods = 0;
    else if (m_pos == 0) m_periods = applied ? 1 : m_periods + 1;
    e_ci = m_on && (m_pos < (m_div + 1) / 2);
    e_ps = m_on && (m_pos == 0);
    e_lk = running && (m_periods >= 3);
    hist.push_back(e_ci);
    if (hist.size() > 24) void'(hist.pop_front());
    e_co  = hist[hist.size() - 1 - m_skew];
    e_rdy = (pend_div.size() == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("clk_ideal", clk_ideal, e_ci);
    chk("clk_out", clk_out, e_co);
    chk("period_start", period_start, e_ps);
    chk("locked", locked, e_lk);
    chk("cfg_ready", cfg_ready, e_rdy);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_skew = '0;
    repeat (2) step();
    chk("rst_clk_ideal", clk_ideal, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_cfg_ready", cfg_ready, 1);

    // Default divide-by-2 start: alternating output, lock on the third period start.
    rst = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("div2_clk_ideal", clk_ideal, k % 2);
      chk("div2_period_start", period_start, k % 2);
      chk("div2_locked", locked, (k >= 5) ? 1 : 0);
    end

    // Clamp check from a stopped generator: div 0 -> 2, skew 15 -> 1.
    rst = 1'b1; enable = 1'b0;
    step();
    rst = 1'b0; cfg_valid = 1'b1; cfg_div = 8'd0; cfg_skew = 4'd15;
    step();
    cfg_valid = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("clamp_clk_ideal", clk_ideal, k % 2);
      chk("clamp_clk_out", clk_out, (k + 1) % 2);
    end

    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      cfg_valid = ($urandom_range(0, 39) == 0);
      cfg_div   = 8'($urandom_range(0, 12));
      cfg_skew  = 4'($urandom_range(0, 15));
      rst       = ($urandom_range(0, 699) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
